// File: rtl/wb_stage_pkg.sv
// Shared constants and the MEM->WB payload for the writeback stage.
package wb_stage_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ECODE_W    = 6;
    localparam int unsigned ESUBCODE_W = 9;
    localparam int unsigned CSR_NUM_W  = 14;

    localparam logic [ECODE_W-1:0] ECODE_INT  = ECODE_W'(6'h00);
    localparam logic [ECODE_W-1:0] ECODE_ADEF = ECODE_W'(6'h08);
    localparam logic [ECODE_W-1:0] ECODE_ALE  = ECODE_W'(6'h09);
    localparam logic [ECODE_W-1:0] ECODE_SYS  = ECODE_W'(6'h0B);
    localparam logic [ECODE_W-1:0] ECODE_BRK  = ECODE_W'(6'h0C);
    localparam logic [ECODE_W-1:0] ECODE_INE  = ECODE_W'(6'h0D);

    localparam logic [CSR_NUM_W-1:0] CSR_CRMD   = CSR_NUM_W'(14'h000);
    localparam logic [CSR_NUM_W-1:0] CSR_PRMD   = CSR_NUM_W'(14'h001);
    localparam logic [CSR_NUM_W-1:0] CSR_EUEN   = CSR_NUM_W'(14'h002);
    localparam logic [CSR_NUM_W-1:0] CSR_ECFG   = CSR_NUM_W'(14'h004);
    localparam logic [CSR_NUM_W-1:0] CSR_ESTAT  = CSR_NUM_W'(14'h005);
    localparam logic [CSR_NUM_W-1:0] CSR_ERA    = CSR_NUM_W'(14'h006);
    localparam logic [CSR_NUM_W-1:0] CSR_BADV   = CSR_NUM_W'(14'h007);
    localparam logic [CSR_NUM_W-1:0] CSR_EENTRY = CSR_NUM_W'(14'h00C);
    localparam logic [CSR_NUM_W-1:0] CSR_SAVE0  = CSR_NUM_W'(14'h030);
    localparam logic [CSR_NUM_W-1:0] CSR_SAVE1  = CSR_NUM_W'(14'h031);
    localparam logic [CSR_NUM_W-1:0] CSR_SAVE2  = CSR_NUM_W'(14'h032);
    localparam logic [CSR_NUM_W-1:0] CSR_SAVE3  = CSR_NUM_W'(14'h033);
    localparam logic [CSR_NUM_W-1:0] CSR_TID    = CSR_NUM_W'(14'h040);
    localparam logic [CSR_NUM_W-1:0] CSR_TCFG   = CSR_NUM_W'(14'h041);
    localparam logic [CSR_NUM_W-1:0] CSR_TVAL   = CSR_NUM_W'(14'h042);
    localparam logic [CSR_NUM_W-1:0] CSR_TICLR  = CSR_NUM_W'(14'h044);

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic                  rf_we;
        logic [REG_ADDR_W-1:0] rf_waddr;
        logic [DATA_W-1:0]     rf_wdata;
        logic                  csr_re;
        logic                  csr_we;
        logic [CSR_NUM_W-1:0]  csr_num;
        logic [DATA_W-1:0]     csr_wmask;
        logic [DATA_W-1:0]     csr_wvalue;
        logic                  ex;
        logic [ECODE_W-1:0]    ecode;
        logic [ESUBCODE_W-1:0] esubcode;
        logic                  ertn;
    } ws_bus_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: commits register/CSR writes, raises exceptions and ertn,
// and counts retired instructions.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic        ms_csr_re,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        ms_ex,
    input  logic [5:0]  ms_ecode,
    input  logic [8:0]  ms_esubcode,
    input  logic        ms_ertn,

    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,

    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    output logic        ws_flush,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,

    output logic [31:0] retire_cnt
);

    logic    ws_valid;
    logic    ws_ready_go;
    ws_bus_t ms_bus;
    ws_bus_t ws_q;

    assign ms_bus = '{
        pc:         ms_pc,
        rf_we:      ms_rf_we,
        rf_waddr:   ms_rf_waddr,
        rf_wdata:   ms_rf_wdata,
        csr_re:     ms_csr_re,
        csr_we:     ms_csr_we,
        csr_num:    ms_csr_num,
        csr_wmask:  ms_csr_wmask,
        csr_wvalue: ms_csr_wvalue,
        ex:         ms_ex,
        ecode:      ms_ecode,
        esubcode:   ms_esubcode,
        ertn:       ms_ertn
    };

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // An instruction arriving while WB flushes is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid && !ws_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (ws_allowin && ms_to_ws_valid) begin
            ws_q <= ms_bus;
        end
    end

    // ertn counts as retired; faulting instructions do not.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= 32'd0;
        end else if (ws_valid && !ws_q.ex) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    // ex takes priority over ertn when both are set.
    assign wb_ex       = ws_valid && ws_q.ex;
    assign ertn_flush  = ws_valid && ws_q.ertn && !ws_q.ex;
    assign ws_flush    = wb_ex || ertn_flush;
    assign wb_ecode    = ws_q.ecode;
    assign wb_esubcode = ws_q.esubcode;
    assign wb_pc       = ws_q.pc;

    assign csr_re     = ws_valid && ws_q.csr_re;
    assign csr_we     = ws_valid && ws_q.csr_we && !ws_q.ex;
    assign csr_num    = ws_q.csr_num;
    assign csr_wmask  = ws_q.csr_wmask;
    assign csr_wvalue = ws_q.csr_wvalue;

    // csr_rvalue is combinational, so a read returns the pre-write value.
    assign rf_we    = ws_valid && ws_q.rf_we && !ws_q.ex;
    assign rf_waddr = ws_q.rf_waddr;
    assign rf_wdata = ws_q.csr_re ? csr_rvalue : ws_q.rf_wdata;

    assign debug_wb_pc       = ws_q.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have clock and reset: clk, synchronous active-high reset named reset.
REQ-002 Ports: clk in 1, rising-edge clock.
REQ-003 Ports: reset in 1, synchronous, active-high.
REQ-004 Ports: ms_to_ws_valid in 1, MEM holds an instruction for WB.
REQ-005 Ports: ws_allowin out 1, WB accepts this cycle.
REQ-006 Ports: ms_pc in 32; ms_rf_we in 1; ms_rf_waddr in 5; ms_rf_wdata in 32.
REQ-007 Ports: ms_csr_re in 1; ms_csr_we in 1; ms_csr_num in 14; ms_csr_wmask in 32; ms_csr_wvalue in 32.
REQ-008 Ports: ms_ex in 1; ms_ecode in 6; ms_esubcode in 9; ms_ertn in 1.
REQ-009 Ports: csr_re out 1; csr_num out 14; csr_rvalue in 32; csr_we out 1; csr_wmask out 32; csr_wvalue out 32.
REQ-010 Ports: wb_ex out 1; wb_ecode out 6; wb_esubcode out 9; wb_pc out 32; ertn_flush out 1.
REQ-011 Ports: ws_flush out 1, cancel to pre-IF..MEM.
REQ-012 Ports: rf_we out 1; rf_waddr out 5; rf_wdata out 32, also the forwarding source for ID.
REQ-013 Ports: debug_wb_pc out 32; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out 32.
REQ-014 Ports: retire_cnt out 32, count of committed instructions.

Function
REQ-015 Pipeline register ws_* SHALL hold all ms_* fields, loaded on the cycle where ws_allowin && ms_to_ws_valid.
REQ-016 ws_ready_go SHALL be 1; ws_allowin = !ws_valid || ws_ready_go.
REQ-017 When ws_allowin: ws_valid <= ms_to_ws_valid && !ws_flush; an instruction arriving in the flush cycle SHALL be dropped.
REQ-018 wb_ex = ws_valid && ws_ex; ertn_flush = ws_valid && ws_ertn && !ws_ex; ws_flush = wb_ex || ertn_flush; all combinational from the WB register.
REQ-019 wb_ecode, wb_esubcode and wb_pc SHALL equal the latched ws_ecode, ws_esubcode and ws_pc; they are only meaningful while wb_ex=1.
REQ-020 csr_we = ws_valid && ws_csr_we && !ws_ex; csr_re = ws_valid && ws_csr_re; csr_num, csr_wmask and csr_wvalue come straight from the register.
REQ-021 rf_we = ws_valid && ws_rf_we && !ws_ex; rf_waddr = ws_rf_waddr; rf_wdata = ws_csr_re ? csr_rvalue : ws_rf_wdata.
REQ-022 The csrrd/csrxchg read value SHALL be the pre-write CSR value, since csr_rvalue is combinational and the CSR write takes effect at the clock edge.
REQ-023 The debug_wb_* outputs SHALL mirror the rf_* outputs; debug_wb_rf_we = {4{rf_we}}; debug_wb_pc = ws_pc.
REQ-024 An instruction with ms_ex=1 and ms_ertn=1 SHALL be treated as an exception only.
REQ-025 retire_cnt SHALL increment by 1 on each cycle with ws_valid && !ws_ex, ertn included, and wrap 0xFFFFFFFF to 0.
REQ-026 ws_flush SHALL be high for exactly one cycle per faulting or ertn instruction, because ws_valid clears the next cycle unless a new instruction enters.
REQ-027 Back-to-back: a valid instruction entering the cycle after a flush SHALL be accepted normally.

Reset
REQ-028 On reset: ws_valid=0 and retire_cnt=0; all gated outputs (wb_ex, ertn_flush, ws_flush, csr_we, csr_re, rf_we) SHALL be 0 in the cycle after reset is sampled.
REQ-029 Datapath ws_* fields other than ws_valid SHALL NOT require reset.
REQ-030 Reset asserted while a faulting instruction sits in WB SHALL suppress wb_ex from the next cycle.

Structure
REQ-031 A shared package SHALL hold the CSR number constants, the ECODE constants (SYS=0x0B, BRK=0x0C, INE=0x0D, ADEF=0x08, ALE=0x09, INT=0x00) and the field widths (ecode 6, esubcode 9, csr_num 14).
REQ-032 Single module, with the retire counter inline; no sub-module.

Verification
REQ-033 Normal write: MEM pc=0x1C000010, rf_we=1, waddr=5, wdata=0x1234 -> next cycle rf_we=1, waddr=5, rf_wdata=0x1234, debug_wb_rf_we=0xF, retire_cnt +1.
REQ-034 Exception: ms_ex=1, ecode=0x0B, pc=0x1C000020, rf_we=1, csr_we=1 -> wb_ex=1, wb_pc=0x1C000020, wb_ecode=0x0B, ws_flush=1 for 1 cycle, rf_we=0, csr_we=0, retire_cnt unchanged.
REQ-035 Flush drop: a faulting instruction in WB with ms_to_ws_valid=1 in the same cycle -> ws_valid=0 next cycle, no rf_we for the dropped instruction.
REQ-036 csrrd: ms_csr_re=1, csr_num=0x30, csr_rvalue=0xDEADBEEF, ms_rf_wdata=0 -> rf_wdata=0xDEADBEEF.
REQ-037 ertn: ms_ertn=1 -> ertn_flush=1, wb_ex=0, ws_flush=1; with ms_ex=1 also set -> wb_ex=1, ertn_flush=0.
REQ-038 Reset mid-operation, plus counter wrap: assert reset with a valid instruction in WB -> next cycle all gated outputs 0 and retire_cnt=0; force retire_cnt=0xFFFFFFFF, commit one instruction -> retire_cnt=0.
